// File: rtl/ram_bist_master.sv
// Built-in self-test and initialisation engine for a single-port RAM:
// fills every word with seed+address, reads it all back and counts mismatches.
module ram_bist_master #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_cnt,
  output logic              pass,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [ADDR_W:0]     err_q, err_d;
  logic                pass_q, pass_d;
  logic [DATA_W-1:0]   pattern;
  logic                mismatch;

  // Expected word for the current address; wraps modulo 2**DATA_W.
  assign pattern  = seed_q + DATA_W'(cnt_q);
  // Case inequality so an unknown read value is counted as a failure.
  assign mismatch = (mem_rd_data !== pattern);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;
    err_d       = err_q;
    pass_d      = pass_q;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          cnt_d   = '0;
          seed_d  = seed;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      S_WRITE: begin
        mem_wr_en   = 1'b1;
        mem_addr    = cnt_q;
        mem_wr_data = pattern;
        busy        = 1'b1;
        if (cnt_q == '1) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_READ: begin
        mem_addr = cnt_q;
        busy     = 1'b1;
        if (mismatch) begin
          err_d = err_q + (ADDR_W+1)'(1);
        end
        if (cnt_q == '1) begin
          state_d = S_DONE;
          cnt_d   = '0;
          pass_d  = (err_d == '0);
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign err_cnt   = err_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_bist_master.sv
// Directed bench for ram_bist_master with a 4x8 RAM model and per-address read-fault injection.
module tb_ram_bist_master;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] seed;
  logic [1:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic       busy;
  logic       done;
  logic [2:0] err_cnt;
  logic       pass;
  logic [1:0] dbg_state;

  logic [7:0] ram [4];
  logic [3:0] flip;
  logic       pl_en;
  logic [1:0] pl_addr;
  logic [7:0] pl_data;

  int checks = 0;
  int errors = 0;

  ram_bist_master #(.ADDR_W(2), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data),
    .busy       (busy),
    .done       (done),
    .err_cnt    (err_cnt),
    .pass       (pass),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: DUT port has priority; pl_* is a bench-only preload port.
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
    else if (pl_en) ram[pl_addr] <= pl_data;
  end
  assign mem_rd_data = ram[mem_addr] ^ {7'd0, flip[mem_addr]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] vals);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = 2'(i);
      pl_data = vals[8*i +: 8];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic chk_ram(input string tag, input logic [31:0] vals);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s/ram%0d", tag, i), 32'(ram[i]), 32'(vals[8*i +: 8]));
    end
  endtask

  // Pulses start, then watches a fixed window of cycles; cycle c is the one after edge E(c-1).
  task automatic run_test(input string name, input logic [7:0] seed_v, input bit inject,
                          input bit b2b, input int exp_err, input bit exp_pass);
    int         busy_n;
    int         done_n;
    int         first_done;
    int         last_c;
    int         k;
    logic [7:0] seed_exp;
    logic [7:0] exp_data;
    busy_n     = 0;
    done_n     = 0;
    first_done = 0;
    last_c     = b2b ? 21 : 12;
    @(negedge clk);
    start = 1'b1;
    seed  = seed_v;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      k        = (b2b && c >= 11) ? c - 10 : c;
      seed_exp = (b2b && c >= 11) ? 8'h80 : seed_v;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (first_done == 0) first_done = c;
      end
      if (c == 1 || (b2b && c == 11)) begin
        chk({name, "/err_clr"}, 32'(err_cnt), 32'd0);
        chk({name, "/pass_clr"}, 32'(pass), 32'd0);
      end
      if (k >= 1 && k <= 4) begin
        exp_data = seed_exp + 8'(k - 1);
        chk({name, "/wr_en"}, 32'(mem_wr_en), 32'd1);
        chk({name, "/wr_addr"}, 32'(mem_addr), 32'(k - 1));
        chk({name, "/wr_data"}, 32'(mem_wr_data), 32'(exp_data));
      end else if (k >= 5 && k <= 8) begin
        chk({name, "/rd_wr_en"}, 32'(mem_wr_en), 32'd0);
        chk({name, "/rd_addr"}, 32'(mem_addr), 32'(k - 5));
        chk({name, "/rd_wdata"}, 32'(mem_wr_data), 32'd0);
      end
      start = (inject && (c == 2 || c == 6)) || (b2b && c == 10);
      if (inject && start) seed = 8'h55;
      if (b2b && c == 10) seed = 8'h80;
    end
    start = 1'b0;
    chk({name, "/busy_cycles"}, 32'(busy_n), b2b ? 32'd16 : 32'd8);
    chk({name, "/done_count"}, 32'(done_n), b2b ? 32'd2 : 32'd1);
    chk({name, "/done_cycle"}, 32'(first_done), 32'd9);
    chk({name, "/err_cnt"}, 32'(err_cnt), 32'(exp_err));
    chk({name, "/pass"}, 32'(pass), 32'(exp_pass));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_n;
    rst   = 1'b1;
    start = 1'b0;
    seed  = 8'h00;
    flip  = 4'b0000;
    pl_en = 1'b0;
    pl_addr = 2'd0;
    pl_data = 8'd0;
    preload(32'h0000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst/wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst/addr", 32'(mem_addr), 32'd0);
    chk("rst/wdata", 32'(mem_wr_data), 32'd0);
    chk("rst/busy", 32'(busy), 32'd0);
    chk("rst/done", 32'(done), 32'd0);
    chk("rst/err", 32'(err_cnt), 32'd0);
    chk("rst/pass", 32'(pass), 32'd0);
    chk("rst/state", 32'(dbg_state), 32'd0);

    run_test("t1", 8'h10, 1'b0, 1'b0, 0, 1'b1);
    chk_ram("t1", 32'h1312_1110);

    run_test("t2", 8'hFE, 1'b0, 1'b0, 0, 1'b1);
    chk_ram("t2", 32'h0100_FFFE);

    flip = 4'b0100;
    run_test("t3a", 8'h10, 1'b0, 1'b0, 1, 1'b0);
    chk_ram("t3a", 32'h1312_1110);
    flip = 4'b1111;
    run_test("t3b", 8'h10, 1'b0, 1'b0, 4, 1'b0);
    flip = 4'b0000;

    run_test("t4", 8'h10, 1'b1, 1'b0, 0, 1'b1);
    chk_ram("t4", 32'h1312_1110);

    preload(32'hA3A2_A1A0);
    @(negedge clk);
    start = 1'b1;
    seed  = 8'h10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5/busy", 32'(busy), 32'd0);
    chk("t5/wr_en", 32'(mem_wr_en), 32'd0);
    chk("t5/done", 32'(done), 32'd0);
    chk("t5/err", 32'(err_cnt), 32'd0);
    chk("t5/pass", 32'(pass), 32'd0);
    chk("t5/state", 32'(dbg_state), 32'd0);
    done_n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("t5/no_done", 32'(done_n), 32'd0);
    chk_ram("t5", 32'hA3A2_1110);
    run_test("t5r", 8'h10, 1'b0, 1'b0, 0, 1'b1);

    run_test("t6", 8'h10, 1'b0, 1'b1, 0, 1'b1);
    chk_ram("t6", 32'h8382_8180);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
